// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory port arbiter.
//   mem_op_e    - data-side operation codes (dm_op)
//   mem_size_e  - access size codes (dm_size)
//   arb_state_e - arbiter FSM state encoding
//   owner_e     - which requester owns the outstanding transaction
//   dm_misaligned() - alignment / upstream bus-error check for data requests
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_DISABLE   = 2'b00,
    MEM_READ_SEXT = 2'b01,
    MEM_READ_ZEXT = 2'b10,
    MEM_WRITE     = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    ERR  = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // A data request is refused without a bus cycle when upstream flagged it
  // or when a word/halfword is not naturally aligned.
  function automatic logic dm_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset,
                                         input logic       bus_err);
    logic bad;
    bad = bus_err;
    if ((size == WORD) && (offset != 2'b00)) bad = 1'b1;
    if ((size == HALFWORD) && offset[0])     bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// mem_load_fmt: combinational load-data formatter.
// Byte offset k lives in lane 3-k (rdata[31-8k:24-8k]); this block picks the
// addressed byte/halfword/word, reassembles it in address order and applies
// sign or zero extension. Non-load ops produce zero.
//   rdata  in  32 - raw memory read data
//   offset in   2 - address[1:0] of the access
//   op     in   2 - operation code (mem_op_e)
//   size   in   2 - access size (mem_size_e)
//   data   out 32 - formatted, extended load result
module mem_load_fmt
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  op,
  input  logic [1:0]  size,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  always_comb begin
    lane_b = '0;
    lane_h = '0;
    data   = '0;
    sext   = (op == MEM_READ_SEXT);

    case (offset)
      2'd0:    lane_b = rdata[31:24];
      2'd1:    lane_b = rdata[23:16];
      2'd2:    lane_b = rdata[15:8];
      default: lane_b = rdata[7:0];
    endcase

    // Halfword at offset 0 is {lane2,lane3}; at offset 2 it is {lane0,lane1}.
    lane_h = offset[1] ? {rdata[7:0], rdata[15:8]} : {rdata[23:16], rdata[31:24]};

    if ((op == MEM_READ_SEXT) || (op == MEM_READ_ZEXT)) begin
      case (size)
        BYTE:     data = {{24{sext & lane_b[7]}}, lane_b};
        HALFWORD: data = {{16{sext & lane_h[15]}}, lane_h};
        default:  data = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates an instruction-fetch port and a data port onto
// a single memory bus with one outstanding transaction.
//   clk, rst                  - clock, synchronous active-high reset
//   if_req/if_addr            - fetch request in; if_gnt/if_rvalid/if_rdata/if_err out
//   dm_req/addr/op/size/wen/wdata/busErr - data request in
//   dm_gnt/dm_rvalid/dm_rdata/dm_err/dm_busy - data response / stall out
//   mem_req/addr/wen/wdata    - memory request out; mem_gnt/rvalid/rdata/err in
// Grants are combinational in IDLE; responses are registered one-cycle pulses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,

  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [1:0]  dm_op,
  input  logic [1:0]  dm_size,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  input  logic        dm_busErr,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        dm_busy,

  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, last_q;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    op_q;
  logic [1:0]    size_q;
  logic [3:0]    wen_q;
  logic [CW-1:0] cnt_q;

  logic          if_pulse_q;
  logic          dm_pulse_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          grant_if;
  logic          grant_dm;
  logic          dm_bad;
  logic          timeout;
  logic [31:0]   fmt_data;

  assign dm_bad  = dm_misaligned(dm_size, dm_addr[1:0], dm_busErr);
  assign timeout = (cnt_q == CNT_LAST);

  // Fetch transactions are latched as ZEXT WORD loads, so one formatter
  // instance serves both ports.
  mem_load_fmt u_fmt (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .op     (op_q),
    .size   (size_q),
    .data   (fmt_data)
  );

  // Arbitration: only in IDLE and never during reset; on contention the
  // requester that was not granted last wins.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (dm_req && (!if_req || (last_q == OWNER_FETCH))) grant_dm = 1'b1;
      else if (if_req)                                    grant_if = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = dm_bad ? ERR : REQ;
        else if (grant_if) state_d = REQ;
      end
      REQ:     if (mem_gnt) state_d = RESP;
      RESP:    if (mem_rvalid || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, RESP counter and registered response pulses.
  // The ERR state arms the same response register as RESP, so an errored
  // data request reports one cycle after leaving ERR, like every other reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWNER_FETCH;
      last_q     <= OWNER_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      size_q     <= '0;
      wen_q      <= '0;
      cnt_q      <= '0;
      if_pulse_q <= 1'b0;
      dm_pulse_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if_pulse_q <= 1'b0;
      dm_pulse_q <= 1'b0;
      err_q      <= 1'b0;

      if (grant_dm) begin
        owner_q <= OWNER_DATA;
        last_q  <= OWNER_DATA;
        addr_q  <= dm_addr;
        op_q    <= dm_op;
        size_q  <= dm_size;
        wen_q   <= dm_wen;
        wdata_q <= dm_wdata;
      end else if (grant_if) begin
        owner_q <= OWNER_FETCH;
        last_q  <= OWNER_FETCH;
        addr_q  <= if_addr;
        op_q    <= MEM_READ_ZEXT;
        size_q  <= WORD;
        wen_q   <= '0;
        wdata_q <= '0;
      end

      if ((state_q == REQ) && mem_gnt) cnt_q <= '0;

      if (state_q == RESP) begin
        cnt_q <= cnt_q + 1'b1;
        if (mem_rvalid || timeout) begin
          if_pulse_q <= (owner_q == OWNER_FETCH);
          dm_pulse_q <= (owner_q == OWNER_DATA);
          // A response arriving on the last counted cycle beats the timeout.
          err_q      <= mem_rvalid ? mem_err : 1'b1;
          rdata_q    <= mem_rvalid ? fmt_data : '0;
        end
      end

      if (state_q == ERR) begin
        dm_pulse_q <= 1'b1;
        err_q      <= 1'b1;
        rdata_q    <= '0;
      end
    end
  end

  // Outputs
  always_comb begin
    if_gnt    = grant_if;
    dm_gnt    = grant_dm;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wen   = '0;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    if_err    = 1'b0;
    if_rdata  = '0;
    dm_rvalid = 1'b0;
    dm_err    = 1'b0;
    dm_rdata  = '0;
    dm_busy   = 1'b0;

    if (!rst) begin
      if (state_q == REQ) begin
        mem_req   = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wen   = (op_q == MEM_WRITE) ? wen_q : 4'b0000;
      end

      if_rvalid = if_pulse_q;
      if_err    = if_pulse_q & err_q;
      if_rdata  = if_pulse_q ? rdata_q : '0;

      dm_rvalid = dm_pulse_q;
      dm_err    = dm_pulse_q & err_q;
      dm_rdata  = dm_pulse_q ? rdata_q : '0;

      dm_busy   = grant_dm || dm_pulse_q ||
                  ((owner_q == OWNER_DATA) && (state_q != IDLE));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam logic [1:0] OP_SEXT  = 2'b01;
  localparam logic [1:0] OP_ZEXT  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [1:0]  dm_op, dm_size;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic        dm_busErr;
  logic        dm_gnt, dm_rvalid, dm_err, dm_busy;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_op(dm_op), .dm_size(dm_size),
    .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_busErr(dm_busErr),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .dm_busy(dm_busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  // Drives one data transaction acting as memory; returns what was observed.
  task automatic dm_txn(input logic [31:0] a, input logic [1:0] op, input logic [1:0] sz,
                        input logic [3:0] wen, input logic [31:0] wd, input int gnt_wait,
                        input logic [31:0] rd, input logic merr,
                        output logic granted, output logic [31:0] req_addr,
                        output logic [3:0] req_wen, output logic [31:0] req_wdata,
                        output int lat, output logic [31:0] got, output logic gerr);
    dm_req = 1'b1; dm_addr = a; dm_op = op; dm_size = sz; dm_wen = wen; dm_wdata = wd;
    dm_busErr = 1'b0;
    #1 granted = dm_gnt;
    @(negedge clk); dm_req = 1'b0;
    for (int i = 0; i < gnt_wait; i++) @(negedge clk);
    #1;
    req_addr = mem_addr; req_wen = mem_wen; req_wdata = mem_wdata;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd; mem_err = merr;
    lat = -1; got = '0; gerr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (dm_rvalid === 1'b1) begin
        lat = i; got = dm_rdata; gerr = dm_err;
        break;
      end
      @(negedge clk); mem_rvalid = 1'b0; mem_err = 1'b0;
    end
    mem_rvalid = 1'b0; mem_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h100; dm_addr = 32'h200;
    #1;
    total++; if (dm_gnt !== 1'b0 || if_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: dm_gnt=%b if_gnt=%b want 0 0", dm_gnt, if_gnt); end
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wen !== 4'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem: req=%b addr=%h wen=%h wdata=%h want zeros", mem_req, mem_addr, mem_wen, mem_wdata); end
    total++; if (dm_busy !== 1'b0 || dm_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp: busy=%b dv=%b iv=%b want 0", dm_busy, dm_rvalid, if_rvalid); end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sext_byte();
    logic g, e; logic [31:0] ra, rw, d; logic [3:0] rwen; int lat;
    dm_txn(32'h1001, OP_SEXT, SZ_BYTE, 4'h0, 32'h0, 2, 32'h11803344, 1'b0, g, ra, rwen, rw, lat, d, e);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL sext_gnt: got %b want 1", g); end
    total++; if (ra !== 32'h1001) begin bad++; $display("FAIL sext_addr_held: got %h want 00001001", ra); end
    total++; if (lat !== 1) begin bad++; $display("FAIL sext_latency: got %0d want 1", lat); end
    total++; if (d !== 32'hFFFFFF80 || e !== 1'b0) begin bad++; $display("FAIL sext_byte: got %h err=%b want ffffff80 err=0", d, e); end
  endtask

  task automatic test_load_formats();
    logic [31:0] addr_v [5] = '{32'h1002, 32'h2000, 32'h1000, 32'h1003, 32'h3000};
    logic [1:0]  op_v   [5] = '{OP_ZEXT, OP_ZEXT, OP_SEXT, OP_SEXT, OP_ZEXT};
    logic [1:0]  sz_v   [5] = '{SZ_HALF, SZ_WORD, SZ_HALF, SZ_BYTE, SZ_WORD};
    logic [31:0] rd_v   [5] = '{32'h0000CDAB, 32'h44332211, 32'h12F00000, 32'h000000AA, 32'h00000000};
    logic        me_v   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_v  [5] = '{32'h0000ABCD, 32'h11223344, 32'hFFFFF012, 32'hFFFFFFAA, 32'h00000000};
    logic g, e; logic [31:0] ra, rw, d; logic [3:0] rwen; int lat;
    for (int i = 0; i < 5; i++) begin
      dm_txn(addr_v[i], op_v[i], sz_v[i], 4'hF, 32'h0, i % 2, rd_v[i], me_v[i], g, ra, rwen, rw, lat, d, e);
      total++; if (d !== exp_v[i] || e !== me_v[i] || lat !== 1) begin bad++; $display("FAIL load_fmt[%0d]: data=%h err=%b lat=%0d want %h %b 1", i, d, e, lat, exp_v[i], me_v[i]); end
      total++; if (rwen !== 4'h0 || ra !== addr_v[i]) begin bad++; $display("FAIL load_bus[%0d]: wen=%h addr=%h want 0 %h", i, rwen, ra, addr_v[i]); end
    end
  endtask

  task automatic test_store();
    logic g, e; logic [31:0] ra, rw, d; logic [3:0] rwen; int lat;
    dm_txn(32'h2004, OP_WRITE, SZ_WORD, 4'b1010, 32'hDEADBEEF, 1, 32'h5555AAAA, 1'b0, g, ra, rwen, rw, lat, d, e);
    total++; if (rwen !== 4'b1010 || rw !== 32'hDEADBEEF || ra !== 32'h2004) begin bad++; $display("FAIL store_bus: wen=%b wdata=%h addr=%h want 1010 deadbeef 00002004", rwen, rw, ra); end
    total++; if (lat !== 1 || d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL store_resp: lat=%0d data=%h err=%b want 1 0 0", lat, d, e); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addr_v [3] = '{32'h1002, 32'h1001, 32'h1000};
    logic [1:0]  op_v   [3] = '{OP_WRITE, OP_ZEXT, OP_SEXT};
    logic [1:0]  sz_v   [3] = '{SZ_WORD, SZ_HALF, SZ_BYTE};
    logic        be_v   [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      dm_req = 1'b1; dm_addr = addr_v[i]; dm_op = op_v[i]; dm_size = sz_v[i];
      dm_wen = 4'hF; dm_wdata = 32'h12345678; dm_busErr = be_v[i];
      #1;
      total++; if (dm_gnt !== 1'b1) begin bad++; $display("FAIL misal_gnt[%0d]: got %b want 1", i, dm_gnt); end
      @(negedge clk); dm_req = 1'b0; dm_busErr = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0 || dm_rvalid !== 1'b0 || dm_busy !== 1'b1) begin bad++; $display("FAIL misal_t1[%0d]: mem_req=%b rvalid=%b busy=%b want 0 0 1", i, mem_req, dm_rvalid, dm_busy); end
      @(negedge clk); #1;
      total++; if (dm_rvalid !== 1'b1 || dm_err !== 1'b1 || mem_req !== 1'b0 || dm_busy !== 1'b1) begin bad++; $display("FAIL misal_t2[%0d]: rvalid=%b err=%b mem_req=%b busy=%b want 1 1 0 1", i, dm_rvalid, dm_err, mem_req, dm_busy); end
      @(negedge clk); #1;
      total++; if (dm_rvalid !== 1'b0 || dm_busy !== 1'b0) begin bad++; $display("FAIL misal_t3[%0d]: rvalid=%b busy=%b want 0 0", i, dm_rvalid, dm_busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_arbitration();
    logic seq [4];
    logic exp_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int ng = 0; int n_if = 0; int n_dm = 0;
    logic gprev = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    dm_addr = 32'h5000; dm_op = OP_ZEXT; dm_size = SZ_WORD; dm_wen = 4'h0; dm_busErr = 1'b0;
    if_addr = 32'h6000; mem_rdata = 32'h44332211; mem_err = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (ng == 4) begin if_req = 1'b0; dm_req = 1'b0; end
      mem_rvalid = gprev;
      #1;
      if (ng < 4 && dm_gnt === 1'b1) begin seq[ng] = 1'b1; ng++; end
      else if (ng < 4 && if_gnt === 1'b1) begin seq[ng] = 1'b0; ng++; end
      if (if_rvalid === 1'b1) begin
        n_if++;
        total++; if (if_rdata !== 32'h11223344 || if_err !== 1'b0) begin bad++; $display("FAIL fetch_data: got %h err=%b want 11223344 0", if_rdata, if_err); end
      end
      if (dm_rvalid === 1'b1) n_dm++;
      mem_gnt = mem_req; gprev = mem_req;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    total++; if (ng !== 4) begin bad++; $display("FAIL arb_grants: got %0d grants want 4", ng); end
    for (int i = 0; i < 4; i++) begin
      total++; if (i < ng && seq[i] !== exp_seq[i]) begin bad++; $display("FAIL arb_order[%0d]: got data=%b want data=%b", i, seq[i], exp_seq[i]); end
    end
    total++; if (n_if !== 2 || n_dm !== 2) begin bad++; $display("FAIL arb_responses: fetch=%0d data=%0d want 2 2", n_if, n_dm); end
  endtask

  task automatic test_timeout();
    int seen; logic e; logic [31:0] d; logic busy_mid;
    for (int mode = 0; mode < 2; mode++) begin
      dm_req = 1'b1; dm_addr = 32'h4000; dm_op = OP_ZEXT; dm_size = SZ_WORD; dm_busErr = 1'b0;
      @(negedge clk); dm_req = 1'b0; mem_gnt = 1'b1;
      @(negedge clk); mem_gnt = 1'b0;
      seen = -1; e = 1'b0; d = '0; busy_mid = 1'b0;
      for (int n = 0; n < 40; n++) begin
        if (mode == 1 && n == 15) begin mem_rvalid = 1'b1; mem_rdata = 32'h44332211; end
        #1;
        if (n == 8) busy_mid = dm_busy;
        if (dm_rvalid === 1'b1) begin seen = n; e = dm_err; d = dm_rdata; break; end
        @(negedge clk); mem_rvalid = 1'b0;
      end
      mem_rvalid = 1'b0;
      total++; if (seen !== 16) begin bad++; $display("FAIL timeout_cycle[%0d]: rvalid at %0d want 16", mode, seen); end
      total++; if (e !== (mode == 0) || d !== ((mode == 0) ? 32'h0 : 32'h11223344)) begin bad++; $display("FAIL timeout_resp[%0d]: err=%b data=%h", mode, e, d); end
      total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL timeout_busy[%0d]: got %b want 1", mode, busy_mid); end
      @(negedge clk); #1;
      total++; if (dm_rvalid !== 1'b0) begin bad++; $display("FAIL timeout_pulse[%0d]: rvalid=%b want 0", mode, dm_rvalid); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    // stray mem_rvalid while IDLE must be ignored
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk); mem_rvalid = 1'b0; #1;
    total++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin bad++; $display("FAIL idle_rvalid: if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; #1;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", if_gnt); end
    @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    total++; if (mem_req !== 1'b0 || if_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rst: mem_req=%b if_rvalid=%b want 0 0", mem_req, if_rvalid); end
    @(negedge clk); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h01020304;
    @(negedge clk); mem_rvalid = 1'b0; #1;
    total++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin bad++; $display("FAIL late_rvalid: if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200; #1;
    total++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin bad++; $display("FAIL post_rst_gnt: if=%b dm=%b want 1 0", if_gnt, dm_gnt); end
    @(negedge clk); if_req = 1'b0; #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_wen !== 4'h0) begin bad++; $display("FAIL fetch_bus: req=%b addr=%h wen=%h want 1 00000200 0", mem_req, mem_addr, mem_wen); end
    mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hEFBEADDE;
    @(negedge clk); mem_rvalid = 1'b0; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_err !== 1'b0) begin bad++; $display("FAIL post_rst_fetch: v=%b data=%h err=%b want 1 deadbeef 0", if_rvalid, if_rdata, if_err); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_addr = '0; dm_op = '0;
    dm_size = '0; dm_wen = '0; dm_wdata = '0; dm_busErr = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_sext_byte();
    test_load_formats();
    test_store();
    test_misaligned();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
